// File: rtl/quad_velocity_meas_if.sv
// rtl/quad_velocity_meas_if.sv - encoder pins, enable and measurement outputs of quad_velocity_meas
interface quad_velocity_meas_if;
    logic               i_enc_a;
    logic               i_enc_b;
    logic               i_en;
    logic signed [15:0] o_pv;
    logic               o_valid;
    logic signed [31:0] o_pos;
    logic               o_dir;
    logic               o_err;

    modport master (
        output i_enc_a, i_enc_b, i_en,
        input  o_pv, o_valid, o_pos, o_dir, o_err
    );

    modport slave (
        input  i_enc_a, i_enc_b, i_en,
        output o_pv, o_valid, o_pos, o_dir, o_err
    );
endinterface

// File: rtl/quad_velocity_meas.sv
// rtl/quad_velocity_meas.sv - 4x quadrature decoder with position and per-window velocity
module quad_velocity_meas #(
    parameter int unsigned WINDOW = 50000,
    parameter bit          SAT_EN = 1'b1
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    quad_velocity_meas_if.slave  bus
);
    localparam logic [23:0] LAST = 24'(WINDOW - 1);

    logic [1:0]         meta_q, meta_d, sync_q, sync_d, hist_q, hist_d;
    logic [2:0]         vld_q, vld_d;
    logic [23:0]        cnt_q, cnt_d;
    logic signed [31:0] acc_q, acc_d, pos_q, pos_d;
    logic signed [15:0] pv_q, pv_d;
    logic               valid_q, valid_d, dir_q, dir_d, err_q, err_d;
    logic signed [31:0] delta, sum;
    logic               illegal;

    // vld_q tracks which pipeline stages hold real pin samples since reset release,
    // so the first sample after release only primes the history register
    always_comb begin
        meta_d = {bus.i_enc_a, bus.i_enc_b};
        sync_d = meta_q;
        hist_d = sync_q;
        vld_d  = {vld_q[1:0], 1'b1};

        delta   = '0;
        illegal = 1'b0;
        if (vld_q[2]) begin
            case ({hist_q, sync_q})
                4'b0001, 4'b0111, 4'b1110, 4'b1000: delta = 32'sd1;
                4'b0100, 4'b1101, 4'b1011, 4'b0010: delta = -32'sd1;
                4'b0011, 4'b1100, 4'b0110, 4'b1001: illegal = 1'b1;
                default: ;
            endcase
        end

        pos_d = pos_q + delta;
        dir_d = dir_q;
        if (delta == 32'sd1)       dir_d = 1'b1;
        else if (delta == -32'sd1) dir_d = 1'b0;
        err_d = err_q | illegal;

        sum     = acc_q + delta;
        cnt_d   = '0;
        acc_d   = '0;
        valid_d = 1'b0;
        pv_d    = pv_q;
        if (bus.i_en) begin
            if (cnt_q == LAST) begin
                valid_d = 1'b1;
                if (SAT_EN && sum > 32'sd32767)       pv_d = 16'sh7FFF;
                else if (SAT_EN && sum < -32'sd32768) pv_d = 16'sh8000;
                else                                  pv_d = sum[15:0];
            end else begin
                cnt_d = cnt_q + 24'd1;
                acc_d = sum;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            meta_q  <= '0;
            sync_q  <= '0;
            hist_q  <= '0;
            vld_q   <= '0;
            cnt_q   <= '0;
            acc_q   <= '0;
            pos_q   <= '0;
            pv_q    <= '0;
            valid_q <= 1'b0;
            dir_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            meta_q  <= meta_d;
            sync_q  <= sync_d;
            hist_q  <= hist_d;
            vld_q   <= vld_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            pos_q   <= pos_d;
            pv_q    <= pv_d;
            valid_q <= valid_d;
            dir_q   <= dir_d;
            err_q   <= err_d;
        end
    end

    assign bus.o_pv    = pv_q;
    assign bus.o_valid = valid_q;
    assign bus.o_pos   = pos_q;
    assign bus.o_dir   = dir_q;
    assign bus.o_err   = err_q;
endmodule
